address_sequencer: RTL and testbench

Upstream stage of the 3-to-8 row address decoder. It generates a timed sequence of 3-bit row addresses: up or down, modulo-8 wrap, a programmable number of addresses, and a programmable dwell per address. It runs once or loops continuously. Output `address` drives the decoder's address input directly; `addr_valid` qualifies it so downstream logic can gate the one-hot row.

---
 rtl/address_sequencer.sv | 172 +++++++++++++++++
 tb/tb_address_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/address_sequencer.sv
// address_sequencer
// Generates a timed sequence of row addresses for the 3-to-8 row decoder.
// The sequence counts up or down with wrap modulo 2^ADDR_W. Each pass covers
// a programmable number of addresses, and each address is held for a
// programmable number of cycles. A scan runs once or loops until stopped.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   start       begin a scan (sampled in IDLE only)
//   stop        abort an active scan (sampled in HOLD only)
//   continuous  1 = loop until stop, 0 = single pass
//   dir_down    1 = decrement address, 0 = increment
//   start_addr  first address of the sequence
//   count       addresses per pass, 0 means 2^ADDR_W
//   dwell       each address is held for dwell+1 cycles
//   address     current row address (registered)
//   addr_valid  address is live (registered)
//   busy        scan in progress (registered)
//   done        one-cycle pulse when a scan ends (registered)
module address_sequencer #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic               dir_down,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W:0]    count,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  address,
    output logic               addr_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Shadow copies of the scan configuration, captured at start
    logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_down_q, dir_down_d;
    logic               continuous_q, continuous_d;

    logic [ADDR_W:0]    remaining_q, remaining_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [ADDR_W-1:0]  address_q, address_d;
    logic               addr_valid_q, addr_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // A count of zero encodes a full pass of 2^ADDR_W addresses
    function automatic logic [ADDR_W:0] eff_count(input logic [ADDR_W:0] c);
        return (c == '0) ? {1'b1, {ADDR_W{1'b0}}} : c;
    endfunction

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        count_d      = count_q;
        dwell_d      = dwell_q;
        dir_down_d   = dir_down_q;
        continuous_d = continuous_q;
        remaining_d  = remaining_q;
        dwell_cnt_d  = dwell_cnt_q;
        address_d    = address_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_addr_d = start_addr;
                    count_d      = count;
                    dwell_d      = dwell;
                    dir_down_d   = dir_down;
                    continuous_d = continuous;
                    address_d    = start_addr;
                    remaining_d  = eff_count(count);
                    dwell_cnt_d  = dwell;
                    addr_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_HOLD;
                end
            end

            S_HOLD: begin
                if (stop) begin
                    addr_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else if (remaining_q > (ADDR_W + 1)'(1)) begin
                    // Width of address_q makes the +/-1 wrap modulo 2^ADDR_W
                    address_d   = dir_down_q ? (address_q - ADDR_W'(1))
                                             : (address_q + ADDR_W'(1));
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    dwell_cnt_d = dwell_q;
                end else if (continuous_q) begin
                    address_d   = start_addr_q;
                    remaining_d = eff_count(count_q);
                    dwell_cnt_d = dwell_q;
                end else begin
                    addr_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d      = S_IDLE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_addr_q <= '0;
            count_q      <= '0;
            dwell_q      <= '0;
            dir_down_q   <= 1'b0;
            continuous_q <= 1'b0;
            remaining_q  <= '0;
            dwell_cnt_q  <= '0;
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            count_q      <= count_d;
            dwell_q      <= dwell_d;
            dir_down_q   <= dir_down_d;
            continuous_q <= continuous_d;
            remaining_q  <= remaining_d;
            dwell_cnt_q  <= dwell_cnt_d;
            address_q    <= address_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign address    = address_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer
// Directed bench for address_sequencer with hand-computed expected sequences.
module tb_address_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       continuous;
    logic       dir_down;
    logic [2:0] start_addr;
    logic [3:0] count;
    logic [3:0] dwell;
    logic [2:0] address;
    logic       addr_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    address_sequencer #(
        .ADDR_W (3),
        .DWELL_W(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .continuous(continuous),
        .dir_down  (dir_down),
        .start_addr(start_addr),
        .count     (count),
        .dwell     (dwell),
        .address   (address),
        .addr_valid(addr_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] a, input logic v,
                              input logic b, input logic d);
        chk({tag, ".address"}, 32'(a), 32'(a === a ? address : 3'bx) );
        chk({tag, ".addr_valid"}, 32'(addr_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic kick(input logic [2:0] sa, input logic [3:0] cnt, input logic [3:0] dw,
                        input logic dn, input logic cont);
        start_addr = sa;
        count      = cnt;
        dwell      = dw;
        dir_down   = dn;
        continuous = cont;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Checks the queued addresses one per cycle, then the done cycle
    task automatic check_pass(input string tag);
        logic [2:0] last;
        last = 3'd0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i != 0) tick();
            expect_out($sformatf("%s[%0d]", tag, i), exp_q[i], 1'b1, 1'b1, 1'b0);
            last = exp_q[i];
        end
        tick();
        expect_out({tag, ".end"}, last, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        stop       = 1'b0;
        continuous = 1'b0;
        dir_down   = 1'b0;
        start_addr = 3'd5;
        count      = 4'd3;
        dwell      = 4'd0;

        // Reset held with start high: nothing may begin
        tick();
        expect_out("rst0", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst1", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b1;
        tick();
        expect_out("idle_stop", 3'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // Single pass up, no dwell
        kick(3'd5, 4'd3, 4'd0, 1'b0, 1'b0);
        exp_q = '{3'd5, 3'd6, 3'd7};
        check_pass("up3");
        tick();
        expect_out("up3.idle", 3'd7, 1'b0, 1'b0, 1'b0);

        // Dwell of 1 with wrap 7->0
        kick(3'd6, 4'd4, 4'd1, 1'b0, 1'b0);
        exp_q = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1};
        check_pass("dwell1");
        tick();

        // Full pass down via count=0, wrap 0->7
        kick(3'd2, 4'd0, 4'd0, 1'b1, 1'b0);
        exp_q = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
        check_pass("down8");

        // start during DONE is ignored; held into IDLE it starts the next scan
        start_addr = 3'd0;
        count      = 4'd2;
        dwell      = 4'd0;
        dir_down   = 1'b0;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        expect_out("done_start", 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        expect_out("cont[0]", 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont[1]", 3'd1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont[2]", 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont[3]", 3'd1, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        expect_out("cont.stop", 3'd1, 1'b0, 1'b0, 1'b1);
        stop = 1'b0;
        tick();
        expect_out("cont.idle", 3'd1, 1'b0, 1'b0, 1'b0);

        // stop in the same cycle as an advance: stop wins, address holds
        kick(3'd3, 4'd3, 4'd2, 1'b0, 1'b0);
        expect_out("race[0]", 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("race[1]", 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("race[2]", 3'd3, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        expect_out("race.stop", 3'd3, 1'b0, 1'b0, 1'b1);
        stop = 1'b0;
        tick();

        // Mid-scan input changes are ignored; reset aborts without done
        kick(3'd1, 4'd4, 4'd0, 1'b0, 1'b0);
        expect_out("mid[0]", 3'd1, 1'b1, 1'b1, 1'b0);
        start_addr = 3'd7;
        count      = 4'd1;
        dwell      = 4'd5;
        dir_down   = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        expect_out("mid[1]", 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("mid[2]", 3'd3, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("mid.rst", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("mid.post0", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("mid.post1", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
